// File: rtl/mctl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle sequencer: FSM states,
// instruction classes, opcode patterns and ALUOp encodings.
package mctl_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ADDI,
        CLS_LDUR,
        CLS_STUR,
        CLS_CBZ,
        CLS_CBNZ,
        CLS_B,
        CLS_ILLEGAL
    } iclass_t;

    localparam logic [10:0] OP_ADD  = 11'd1112;
    localparam logic [10:0] OP_SUB  = 11'd1624;
    localparam logic [10:0] OP_AND  = 11'd1104;
    localparam logic [10:0] OP_ORR  = 11'd1360;
    localparam logic [10:0] OP_LDUR = 11'd1986;
    localparam logic [10:0] OP_STUR = 11'd1984;

    // Prefix patterns: CBZ/CBNZ match on OpCode[10:3], B on OpCode[10:5].
    localparam logic [7:0] OP_CBZ_HI  = 8'hB4;
    localparam logic [7:0] OP_CBNZ_HI = 8'hB5;
    localparam logic [5:0] OP_B_HI    = 6'b000101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_PASSB = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Classes whose second register operand is Rt rather than Rm.
    function automatic logic uses_rt(input iclass_t c);
        return (c == CLS_STUR) || (c == CLS_CBZ) || (c == CLS_CBNZ);
    endfunction

endpackage

// File: rtl/mctl_opclass_decode.sv
// Combinational OpCode (IR[31:21]) to instruction-class decoder.
module mctl_opclass_decode
    import mctl_pkg::*;
(
    input  logic [10:0] opcode,
    output iclass_t     iclass
);

    always_comb begin
        iclass = CLS_ILLEGAL;
        if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) begin
            iclass = CLS_RTYPE;
        end else if (opcode == OP_LDUR) begin
            iclass = CLS_LDUR;
        end else if (opcode == OP_STUR) begin
            iclass = CLS_STUR;
        end else if (opcode[10:3] == OP_CBZ_HI) begin
            iclass = CLS_CBZ;
        end else if (opcode[10:3] == OP_CBNZ_HI) begin
            iclass = CLS_CBNZ;
        end else if (opcode[10:5] == OP_B_HI) begin
            iclass = CLS_B;
        end else if (opcode[10] && !opcode[6] && !opcode[5]) begin
            iclass = CLS_ADDI;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// LEGv8 multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) sharing one memory port.
// Optional memory-wait watchdog enabled by defining MCTL_TIMEOUT_EN.
module multicycle_control
    import mctl_pkg::*;
#(
    parameter int unsigned PC_INC         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] OpCode,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic [3:0]  pc_inc,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IRWrite,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        Reg2Loc,
    output logic        ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal,
    output logic        timeout
);

`ifdef MCTL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t  state;
    state_t  state_nxt;
    iclass_t dec_class;
    iclass_t cur_class;

    logic       pc_write;
    logic       pc_src;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg2loc;
    logic       alu_src_b;
    logic [1:0] alu_op;
    logic       illegal_op;

    logic       in_mem_wait;
    logic       expired;
    logic [7:0] wait_cnt;
    logic       timeout_q;

    mctl_opclass_decode u_decode (
        .opcode (OpCode),
        .iclass (dec_class)
    );

    assign in_mem_wait = (state == FETCH) || (state == MEM);
    assign expired     = TIMEOUT_EN && in_mem_wait && (wait_cnt == TIMEOUT_LIMIT);

`ifdef MCTL_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else if (expired) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b1;
        end else if (state_nxt != state) begin
            wait_cnt  <= '0;
        end else if (in_mem_wait && !mem_ready) begin
            wait_cnt  <= wait_cnt + 8'd1;
        end
    end
`else
    assign wait_cnt  = '0;
    assign timeout_q = 1'b0;
`endif

    // The class is latched at the end of DECODE so EXEC/MEM/WB no longer depend on OpCode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            cur_class <= CLS_ILLEGAL;
        end else begin
            state <= state_nxt;
            if (state == DECODE) begin
                cur_class <= dec_class;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        reg2loc    = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;

        case (state)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                reg2loc = uses_rt(dec_class);
                if (dec_class == CLS_ILLEGAL) begin
                    illegal_op = 1'b1;
                    state_nxt  = FETCH;
                end else begin
                    state_nxt  = EXEC;
                end
            end
            EXEC: begin
                state_nxt = FETCH;
                case (cur_class)
                    CLS_RTYPE: begin
                        alu_op    = ALUOP_FUNCT;
                        state_nxt = WB;
                    end
                    CLS_ADDI: begin
                        alu_op    = ALUOP_FUNCT;
                        alu_src_b = 1'b1;
                        state_nxt = WB;
                    end
                    CLS_LDUR, CLS_STUR: begin
                        alu_op    = ALUOP_ADD;
                        alu_src_b = 1'b1;
                        reg2loc   = uses_rt(cur_class);
                        state_nxt = MEM;
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        alu_op   = ALUOP_PASSB;
                        reg2loc  = 1'b1;
                        pc_src   = 1'b1;
                        pc_write = (cur_class == CLS_CBZ) ? Zero : !Zero;
                    end
                    CLS_B: begin
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                    end
                    default: state_nxt = FETCH;
                endcase
            end
            MEM: begin
                iord      = 1'b1;
                mem_read  = (cur_class == CLS_LDUR);
                mem_write = (cur_class == CLS_STUR);
                if (mem_ready) begin
                    state_nxt = (cur_class == CLS_LDUR) ? WB : FETCH;
                end
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (cur_class == CLS_LDUR);
                state_nxt  = FETCH;
            end
            default: state_nxt = FETCH;
        endcase

        // Abandon a stalled access: drop every strobe and restart from fetch.
        if (expired) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            iord      = 1'b0;
            state_nxt = FETCH;
        end
    end

    // Gating with rst_n removes the FETCH read strobe while reset is held.
    assign pc_inc   = 4'(PC_INC);
    assign PCWrite  = rst_n & pc_write;
    assign PCSrc    = rst_n & pc_src;
    assign IRWrite  = rst_n & ir_write;
    assign IorD     = rst_n & iord;
    assign MemRead  = rst_n & mem_read;
    assign MemWrite = rst_n & mem_write;
    assign MemtoReg = rst_n & mem_to_reg;
    assign RegWrite = rst_n & reg_write;
    assign Reg2Loc  = rst_n & reg2loc;
    assign ALUSrcB  = rst_n & alu_src_b;
    assign ALUOp    = rst_n ? alu_op : 2'b00;
    assign illegal  = rst_n & illegal_op;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction phase sequencing model,
// per-cycle output comparison, plus hand-computed literal expectations.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] OpCode;
    logic        Zero;
    logic        mem_ready;
    logic [3:0]  pc_inc;
    logic        PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite;
    logic        MemtoReg, RegWrite, Reg2Loc, ALUSrcB, illegal, timeout;
    logic [1:0]  ALUOp;

    multicycle_control dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .OpCode    (OpCode),
        .Zero      (Zero),
        .mem_ready (mem_ready),
        .pc_inc    (pc_inc),
        .PCWrite   (PCWrite),
        .PCSrc     (PCSrc),
        .IRWrite   (IRWrite),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .Reg2Loc   (Reg2Loc),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .illegal   (illegal),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef enum {PH_R, PH_F, PH_D, PH_E, PH_M, PH_W} phase_e;
    typedef enum {K_RTYPE, K_ADDI, K_LDUR, K_STUR, K_CBZ, K_CBNZ, K_B, K_ILL} cls_e;

    typedef struct packed {
        logic       pcw;
        logic       pcsrc;
        logic       irw;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       rw;
        logic       r2l;
        logic       asb;
        logic [1:0] aop;
        logic       ill;
    } ov_t;

    typedef struct {
        int   op;
        cls_e k;
        logic z;
        int   fw;
        int   mw;
        int   lat;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    ov_t    exp_ov;
    bit     exp_on = 1'b0;
    phase_e cur_ph;
    ov_t    snap;
    bit     snapped;

    function automatic ov_t model(input phase_e ph, input cls_e k, input logic mr, input logic z);
        ov_t o;
        o = '0;
        case (ph)
            PH_F: begin
                o.mrd = 1'b1;
                if (mr) begin
                    o.irw = 1'b1;
                    o.pcw = 1'b1;
                end
            end
            PH_D: begin
                o.r2l = (k == K_STUR) || (k == K_CBZ) || (k == K_CBNZ);
                o.ill = (k == K_ILL);
            end
            PH_E: begin
                case (k)
                    K_RTYPE: o.aop = 2'b10;
                    K_ADDI:  begin o.aop = 2'b10; o.asb = 1'b1; end
                    K_LDUR:  o.asb = 1'b1;
                    K_STUR:  begin o.asb = 1'b1; o.r2l = 1'b1; end
                    K_CBZ:   begin o.aop = 2'b01; o.r2l = 1'b1; o.pcsrc = 1'b1; o.pcw = z; end
                    K_CBNZ:  begin o.aop = 2'b01; o.r2l = 1'b1; o.pcsrc = 1'b1; o.pcw = ~z; end
                    K_B:     begin o.pcw = 1'b1; o.pcsrc = 1'b1; end
                    default: o = '0;
                endcase
            end
            PH_M: begin
                o.iord = 1'b1;
                o.mrd  = (k == K_LDUR);
                o.mwr  = (k == K_STUR);
            end
            PH_W: begin
                o.rw  = 1'b1;
                o.m2r = (k == K_LDUR);
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    function automatic ov_t sample_dut();
        ov_t a;
        a.pcw   = PCWrite;
        a.pcsrc = PCSrc;
        a.irw   = IRWrite;
        a.iord  = IorD;
        a.mrd   = MemRead;
        a.mwr   = MemWrite;
        a.m2r   = MemtoReg;
        a.rw    = RegWrite;
        a.r2l   = Reg2Loc;
        a.asb   = ALUSrcB;
        a.aop   = ALUOp;
        a.ill   = illegal;
        return a;
    endfunction

    always @(negedge clk) begin
        if (exp_on) begin
            ov_t act;
            act = sample_dut();
            checks++;
            if (act !== exp_ov || pc_inc !== 4'd4 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t phase=%s act=%b exp=%b pc_inc=%0d timeout=%b",
                         $time, cur_ph.name(), act, exp_ov, pc_inc, timeout);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic step(input phase_e ph, input cls_e k, input logic [10:0] op,
                        input logic z, input logic mr);
        @(posedge clk);
        #1;
        rst_n     = (ph != PH_R);
        OpCode    = op;
        Zero      = z;
        mem_ready = mr;
        cur_ph    = ph;
        exp_ov    = model(ph, k, mr, z);
        exp_on    = 1'b1;
    endtask

    task automatic run_instr(input int op, input cls_e k, input logic z, input int fw,
                             input int mw, input phase_e probe, output int n);
        logic [10:0] o;
        o = 11'(op);
        n = 0;
        snapped = 1'b0;
        for (int i = 0; i <= fw; i++) begin
            step(PH_F, k, 11'($urandom), 1'($urandom), (i == fw));
            n++;
            if (probe == PH_F && !snapped) begin #1; snap = sample_dut(); snapped = 1'b1; end
        end
        step(PH_D, k, o, 1'($urandom), 1'($urandom));
        n++;
        if (probe == PH_D) begin #1; snap = sample_dut(); snapped = 1'b1; end
        if (k == K_ILL) return;
        step(PH_E, k, o, z, 1'($urandom));
        n++;
        if (probe == PH_E) begin #1; snap = sample_dut(); snapped = 1'b1; end
        if (k == K_LDUR || k == K_STUR) begin
            for (int i = 0; i <= mw; i++) begin
                step(PH_M, k, o, 1'($urandom), (i == mw));
                n++;
                if (probe == PH_M && !snapped) begin #1; snap = sample_dut(); snapped = 1'b1; end
            end
        end
        if (k == K_RTYPE || k == K_ADDI || k == K_LDUR) begin
            step(PH_W, k, o, 1'($urandom), 1'($urandom));
            n++;
            if (probe == PH_W) begin #1; snap = sample_dut(); snapped = 1'b1; end
        end
    endtask

    vec_t tbl[13];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int rise;
        rst_n     = 1'b0;
        OpCode    = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;

        step(PH_R, K_ILL, 11'd0, 1'b0, 1'b1);
        #1;
        chk("reset_memread", MemRead, 0);
        chk("reset_pc_inc", pc_inc, 4);
        chk("reset_timeout", timeout, 0);
        step(PH_R, K_ILL, 11'd0, 1'b0, 1'b0);

        run_instr(1112, K_RTYPE, 1'b0, 0, 0, PH_E, n);
        chk("add_exec_aluop", snap.aop, 2);
        chk("add_latency", n, 4);

        run_instr(1986, K_LDUR, 1'b0, 0, 2, PH_W, n);
        chk("ldur_wb_memtoreg", snap.m2r, 1);
        chk("ldur_wb_regwrite", snap.rw, 1);
        chk("ldur_latency", n, 7);

        run_instr(11'h5A0, K_CBZ, 1'b1, 0, 0, PH_E, n);
        chk("cbz_taken_pcwrite", snap.pcw, 1);
        chk("cbz_taken_pcsrc", snap.pcsrc, 1);
        chk("cbz_latency", n, 3);

        run_instr(11'h5A8, K_CBNZ, 1'b1, 0, 0, PH_E, n);
        chk("cbnz_zero_pcwrite", snap.pcw, 0);

        run_instr(1984, K_STUR, 1'b0, 0, 0, PH_D, n);
        chk("stur_decode_reg2loc", snap.r2l, 1);
        chk("stur_latency", n, 4);

        run_instr(0, K_ILL, 1'b0, 0, 0, PH_D, n);
        chk("illegal_pulse", snap.ill, 1);
        chk("illegal_latency", n, 2);

        tbl[0]  = '{1624, K_RTYPE, 1'b0, 1, 0, 5};
        tbl[1]  = '{1104, K_RTYPE, 1'b1, 0, 0, 4};
        tbl[2]  = '{1360, K_RTYPE, 1'b0, 0, 0, 4};
        tbl[3]  = '{1160, K_ADDI,  1'b0, 0, 0, 4};
        tbl[4]  = '{160,  K_B,     1'b0, 0, 0, 3};
        tbl[5]  = '{1447, K_CBZ,   1'b0, 0, 0, 3};
        tbl[6]  = '{1455, K_CBNZ,  1'b0, 0, 0, 3};
        tbl[7]  = '{1985, K_ILL,   1'b0, 2, 0, 4};
        tbl[8]  = '{1456, K_ILL,   1'b0, 0, 0, 2};
        tbl[9]  = '{1986, K_LDUR,  1'b0, 1, 1, 7};
        tbl[10] = '{1984, K_STUR,  1'b0, 0, 3, 7};
        tbl[11] = '{163,  K_B,     1'b1, 0, 0, 3};
        tbl[12] = '{1936, K_ADDI,  1'b1, 1, 0, 5};
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].op, tbl[i].k, tbl[i].z, tbl[i].fw, tbl[i].mw, PH_R, n);
            chk($sformatf("latency_row%0d", i), n, tbl[i].lat);
        end

        // Reset asserted while a store is stalled in MEM.
        step(PH_F, K_STUR, 11'd0, 1'b0, 1'b1);
        step(PH_D, K_STUR, 11'd1984, 1'b0, 1'b0);
        step(PH_E, K_STUR, 11'd1984, 1'b0, 1'b0);
        step(PH_M, K_STUR, 11'd1984, 1'b0, 1'b0);
        step(PH_M, K_STUR, 11'd1984, 1'b0, 1'b0);
        #1;
        chk("stur_mem_write_before_reset", MemWrite, 1);
        rst_n  = 1'b0;
        cur_ph = PH_R;
        exp_ov = model(PH_R, K_STUR, 1'b0, 1'b0);
        #1;
        chk("reset_drops_memwrite", MemWrite, 0);
        chk("reset_drops_iord", IorD, 0);
        step(PH_R, K_STUR, 11'd1984, 1'b0, 1'b1);
        step(PH_F, K_STUR, 11'd1984, 1'b0, 1'b0);
        #1;
        chk("after_reset_fetch_memread", MemRead, 1);
        run_instr(1112, K_RTYPE, 1'b0, 0, 0, PH_W, n);
        chk("after_reset_add_regwrite", snap.rw, 1);

`ifdef MCTL_TIMEOUT_EN
        step(PH_R, K_ILL, 11'd0, 1'b0, 1'b0);
        @(posedge clk);
        exp_on = 1'b0;
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        rise      = -1;
        for (int i = 1; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (timeout && rise < 0) rise = i;
        end
        chk("timeout_set", timeout, 1);
        chk("timeout_after_255_waits", int'(rise >= 255 && rise <= 258), 1);
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("timeout_sticky", timeout, 1);
`else
        chk("timeout_tied_low", timeout, 0);
        rise = 0;
`endif

        @(posedge clk);
        exp_on = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the LEGv8 datapath; replaces single-cycle decode with an FSM over FETCH/DECODE/EXEC/MEM/WB.
- Shares one unified memory port between instruction fetch and data access via a ready handshake.
- Drives PC/IR write enables, ALU operand selects, ALUOp, memory strobes and register-file write-back.
- Sits between the instruction register (OpCode = IR[31:21]) and the datapath muxes/registers.

Parameters:
- PC_INC, 4, byte increment applied to the PC on a completed fetch; drives pc_inc output.
- TIMEOUT_CYCLES, 255, memory-wait limit, used only with MCTL_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OpCode  in  11  IR[31:21], valid from DECODE onward.
- Zero  in  1  ALU zero flag, sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_inc  out  4  constant PC_INC for the PC adder.
- PCWrite  out  1  load PC this cycle.
- PCSrc  out  1  0 = PC+PC_INC, 1 = branch target.
- IRWrite  out  1  load IR from memory read data.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe, held until mem_ready.
- MemWrite  out  1  memory write strobe, held until mem_ready.
- MemtoReg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register-file write enable.
- Reg2Loc  out  1  second read-register select (1 = Rt).
- ALUSrcB  out  1  0 = register, 1 = sign-extended immediate.
- ALUOp  out  2  00 add, 01 pass-B/compare, 10 funct-decoded.
- illegal  out  1  one-cycle pulse on an undecodable opcode.
- timeout  out  1  sticky error flag (MCTL_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, rst_n=0): state=FETCH; every output 0 except pc_inc; timeout=0.
- Outputs are Moore decodes of the state plus a registered instruction class; PCWrite/IRWrite are additionally qualified by mem_ready/Zero.
- Instruction class is decoded from OpCode in DECODE and registered:
  - RTYPE: ADD 1112, SUB 1624, AND 1104, ORR 1360.
  - ADDI: OpCode[10]=1, [6]=0, [5]=0.
  - LDUR 1986, STUR 1984.
  - CBZ: OpCode[10:3]=8'hB4. CBNZ: OpCode[10:3]=8'hB5.
  - B: OpCode[10:5]=6'b000101.
  - Any other opcode is ILLEGAL.
- FETCH:
  - MemRead=1, IorD=0.
  - Stay in FETCH while mem_ready=0.
  - On mem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
- DECODE: one cycle; Reg2Loc=1 for STUR/CBZ/CBNZ, else 0.
  - ILLEGAL: pulse illegal, return to FETCH.
  - All other classes: go to EXEC.
- EXEC: one cycle.
  - RTYPE: ALUOp=10, ALUSrcB=0, go to WB.
  - ADDI: ALUOp=10, ALUSrcB=1, go to WB.
  - LDUR/STUR: ALUOp=00, ALUSrcB=1, go to MEM.
  - CBZ: ALUOp=01, Reg2Loc=1; PCWrite=Zero, PCSrc=1; go to FETCH.
  - CBNZ: ALUOp=01, Reg2Loc=1; PCWrite=!Zero, PCSrc=1; go to FETCH.
  - B: PCWrite=1, PCSrc=1, go to FETCH.
- MEM:
  - IorD=1; MemRead=1 for LDUR, MemWrite=1 for STUR.
  - Strobes are held while mem_ready=0.
  - On mem_ready: LDUR goes to WB, STUR goes to FETCH.
- WB: one cycle, RegWrite=1, MemtoReg=1 only for LDUR; then go to FETCH.
- Latency with zero-wait memory (each memory wait cycle adds 1):
  - RTYPE/ADDI: 4 cycles. LDUR: 5. STUR: 4. CBZ/CBNZ/B: 3. ILLEGAL: 2.
- MemRead and MemWrite are never asserted together; RegWrite is never asserted in FETCH or MEM.
- mem_ready asserted outside FETCH/MEM is ignored.
- Reset mid-access drops all strobes immediately; no partial write-back occurs.

Optional Feature:
- MCTL_TIMEOUT_EN defined:
  - An 8-bit wait counter counts consecutive mem_ready=0 cycles in FETCH/MEM and clears on state change.
  - When the count reaches TIMEOUT_CYCLES: timeout sets (sticky until reset), strobes drop, FSM enters FETCH.
- Undefined: no counter; waits are unbounded; timeout tied 0.

Decomposition:
- Package mctl_pkg:
  - state enum (FETCH, DECODE, EXEC, MEM, WB).
  - instr-class enum.
  - opcode constants (1112, 1624, 1104, 1360, 1986, 1984; CBZ/CBNZ/B patterns).
  - ALUOp encodings.
- One sub-module, mctl_opclass_decode: combinational OpCode-to-class decoder.

Test Plan:
- ADD (OpCode 1112), mem_ready always 1 -> states F,D,E,W over 4 cycles; RegWrite=1 only in W; ALUOp=10 in E.
- LDUR 1986 with mem_ready low for 2 cycles in MEM -> MemRead and IorD=1 held 3 cycles, then WB with MemtoReg=1, RegWrite=1; 7 cycles total.
- CBZ (OpCode 0x5A0) with Zero=1 -> PCWrite=1, PCSrc=1 in EXEC. CBNZ (0x5A8) with Zero=1 -> PCWrite=0 in EXEC.
- STUR 1984 -> Reg2Loc=1 in D and E; MemWrite=1 in MEM; RegWrite never 1; back to FETCH after 4 cycles.
- OpCode 0 -> illegal pulses once in DECODE; next cycle is FETCH with MemRead=1.
- rst_n low mid-MEM of a STUR -> MemWrite drops asynchronously; state=FETCH after release. With MCTL_TIMEOUT_EN and mem_ready stuck 0 -> timeout=1 after 255 wait cycles.
